// File: rtl/reg_file_ext_if.sv
// rtl/reg_file_ext_if.sv - bus bundle for reg_file_ext: two write ports, two read ports, PC load, clear control.
interface reg_file_ext_if #(
  parameter int N = 32,
  parameter int R = 16
);
  localparam int AW = $clog2(R);

  logic          we3;
  logic [AW-1:0] a3;
  logic [N-1:0]  wd3;
  logic          we4;
  logic [AW-1:0] a4;
  logic [N-1:0]  wd4;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [N-1:0]  rd1;
  logic [N-1:0]  rd2;
  logic [N-1:0]  pc_in;
  logic          clr_req;
  logic          busy;

  modport master (
    output we3, a3, wd3, we4, a4, wd4, a1, a2, pc_in, clr_req,
    input  rd1, rd2, busy
  );

  modport slave (
    input  we3, a3, wd3, we4, a4, wd4, a1, a2, pc_in, clr_req,
    output rd1, rd2, busy
  );
endinterface

// File: rtl/reg_file_ext.sv
// rtl/reg_file_ext.sv - dual-write register file with write bypass, PC register and sequential clear FSM.
module reg_file_ext #(
  parameter int N = 32,
  parameter int R = 16
) (
  input  logic           clk,
  input  logic           rst,
  reg_file_ext_if.slave  bus
);
  localparam int AW = $clog2(R);
  localparam logic [AW-1:0] PC_ADDR = AW'(R - 1);
  localparam logic [AW-1:0] LAST_GP = AW'(R - 2);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [N-1:0]  regs_q [R];

  logic wr_a, wr_b;

  // Writes to the PC slot are dropped; this also keeps them out of the bypass path.
  assign wr_a = bus.we3 && (bus.a3 != PC_ADDR) && (state_q == IDLE);
  assign wr_b = bus.we4 && (bus.a4 != PC_ADDR) && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_GP) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < R; i++) regs_q[i] <= '0;
    end else begin
      regs_q[R-1] <= bus.pc_in;
      for (int i = 0; i < R - 1; i++) begin
        if ((state_q == CLEAR) && (cnt_q == AW'(i)))
          regs_q[i] <= '0;
        else if (wr_b && (bus.a4 == AW'(i)))
          regs_q[i] <= bus.wd4;
        else if (wr_a && (bus.a3 == AW'(i)))
          regs_q[i] <= bus.wd3;
      end
    end
  end

  always_comb begin
    bus.rd1 = regs_q[bus.a1];
    if (wr_b && (bus.a4 == bus.a1))      bus.rd1 = bus.wd4;
    else if (wr_a && (bus.a3 == bus.a1)) bus.rd1 = bus.wd3;

    bus.rd2 = regs_q[bus.a2];
    if (wr_b && (bus.a4 == bus.a2))      bus.rd2 = bus.wd4;
    else if (wr_a && (bus.a3 == bus.a2)) bus.rd2 = bus.wd3;
  end

  assign bus.busy = busy_q;
endmodule

// File: tb/tb_reg_file_ext.sv
// tb/tb_reg_file_ext.sv - scoreboard bench for reg_file_ext against an array-based reference model.
module tb_reg_file_ext;
  localparam int N  = 32;
  localparam int R  = 16;
  localparam int AW = $clog2(R);
  localparam int PC = R - 1;

  logic clk;
  logic rst;

  reg_file_ext_if #(.N(N), .R(R)) bus ();

  reg_file_ext #(.N(N), .R(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] rd1;
    logic [N-1:0] rd2;
    logic         busy;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: plain array plus "clear cycles remaining" and next index.
  logic [N-1:0] model [R];
  int           clr_left = 0;
  int           clr_idx  = 0;

  function automatic logic [N-1:0] model_read(input int addr, input bit we3, input int a3,
                                              input logic [N-1:0] wd3, input bit we4,
                                              input int a4, input logic [N-1:0] wd4);
    if (clr_left == 0) begin
      if (we4 && a4 != PC && a4 == addr) return wd4;
      if (we3 && a3 != PC && a3 == addr) return wd3;
    end
    return model[addr];
  endfunction

  task automatic drive(input bit r, input bit we3, input int a3, input logic [N-1:0] wd3,
                       input bit we4, input int a4, input logic [N-1:0] wd4,
                       input int a1, input int a2, input logic [N-1:0] pc, input bit clr,
                       input string tag);
    exp_t e;
    @(negedge clk);
    rst         = r;
    bus.we3     = we3;
    bus.a3      = AW'(a3);
    bus.wd3     = wd3;
    bus.we4     = we4;
    bus.a4      = AW'(a4);
    bus.wd4     = wd4;
    bus.a1      = AW'(a1);
    bus.a2      = AW'(a2);
    bus.pc_in   = pc;
    bus.clr_req = clr;
    if (r) begin
      for (int i = 0; i < R; i++) model[i] = '0;
      clr_left = 0;
      clr_idx  = 0;
    end
    e.rd1  = model_read(a1, we3, a3, wd3, we4, a4, wd4);
    e.rd2  = model_read(a2, we3, a3, wd3, we4, a4, wd4);
    e.busy = (clr_left != 0);
    e.tag  = tag;
    exp_q.push_back(e);
    if (!r) begin
      model[PC] = pc;
      if (clr_left == 0) begin
        if (we3 && a3 != PC) model[a3] = wd3;
        if (we4 && a4 != PC) model[a4] = wd4;
        if (clr) begin
          clr_left = R - 1;
          clr_idx  = 0;
        end
      end else begin
        model[clr_idx] = '0;
        clr_idx++;
        clr_left--;
      end
    end
  endtask

  task automatic idle_read(input int a1, input int a2, input logic [N-1:0] pc, input string tag);
    drive(1'b0, 1'b0, 0, '0, 1'b0, 0, '0, a1, a2, pc, 1'b0, tag);
  endtask

  // Monitor samples mid-low-phase, well clear of the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 3;
        if (bus.rd1 !== e.rd1) begin
          failures++;
          $display("FAIL %s rd1 got=%h exp=%h t=%0t", e.tag, bus.rd1, e.rd1, $time);
        end
        if (bus.rd2 !== e.rd2) begin
          failures++;
          $display("FAIL %s rd2 got=%h exp=%h t=%0t", e.tag, bus.rd2, e.rd2, $time);
        end
        if (bus.busy !== e.busy) begin
          failures++;
          $display("FAIL %s busy got=%b exp=%b t=%0t", e.tag, bus.busy, e.busy, $time);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] pc;
    rst = 1'b1;
    bus.we3 = 0; bus.a3 = '0; bus.wd3 = '0;
    bus.we4 = 0; bus.a4 = '0; bus.wd4 = '0;
    bus.a1 = '0; bus.a2 = '0; bus.pc_in = '0; bus.clr_req = 0;
    for (int i = 0; i < R; i++) model[i] = '0;

    drive(1'b1, 0, 0, '0, 0, 0, '0, 2, PC, 32'h0, 0, "reset");
    drive(1'b1, 0, 0, '0, 0, 0, '0, 7, 3, 32'h0, 0, "reset");

    // Basic write then read back.
    drive(1'b0, 1, 2, 32'hAAAA5555, 0, 0, '0, 2, 3, 32'h4, 0, "wr_bypass");
    idle_read(2, 3, 32'h8, "rd_after_wr");

    // Same-address dual write: port B wins both in bypass and in storage.
    drive(1'b0, 1, 5, 32'h11, 1, 5, 32'h22, 5, 5, 32'hC, 0, "dual_same_addr");
    idle_read(5, 2, 32'h10, "dual_stored");

    // PC writes dropped, PC tracks pc_in.
    drive(1'b0, 1, PC, 32'hDEAD, 1, PC, 32'hBEEF, PC, PC, 32'h100, 0, "pc_nobypass");
    idle_read(PC, 5, 32'h104, "pc_load");

    // Fill general regs, then one-cycle clear with writes attempted while busy.
    for (int i = 0; i < R - 1; i++)
      drive(1'b0, 1, i, 32'h1000 + i, 0, 0, '0, i, (i + 1) % R, 32'h200 + i, 0, "fill");
    drive(1'b0, 0, 0, '0, 0, 0, '0, 0, 3, 32'h300, 1, "clr_pulse");
    for (int k = 0; k < R + 1; k++)
      drive(1'b0, 1, k % (R - 1), 32'hFFFF, 1, 3, 32'hEEEE, k % R, (k + 4) % R,
            32'h400 + k, 0, "clear_seq");

    // Reset mid-clear, then a fresh clear.
    for (int i = 0; i < R - 1; i++)
      drive(1'b0, 1, i, 32'h2000 + i, 0, 0, '0, i, 14, 32'h500, 0, "fill2");
    drive(1'b0, 0, 0, '0, 0, 0, '0, 0, 14, 32'h600, 1, "clr_pulse2");
    for (int k = 0; k < 7; k++) idle_read(10, 14, 32'h700 + k, "clear_pre_rst");
    drive(1'b1, 0, 0, '0, 0, 0, '0, 10, 14, 32'h0, 0, "rst_abort");
    drive(1'b0, 1, 9, 32'h99, 0, 0, '0, 9, PC, 32'h800, 0, "post_rst");
    drive(1'b0, 0, 0, '0, 0, 0, '0, 9, 1, 32'h804, 1, "clr_fresh");
    for (int k = 0; k < R + 1; k++) idle_read(k % R, 9, 32'h900 + k, "fresh_clear");

    // clr_req held: 15 busy, 1 idle (write accepted), 15 busy.
    for (int k = 0; k < 2 * R + 2; k++)
      drive(1'b0, 1, 6, 32'hA000 + k, 0, 0, '0, 6, 7, 32'hB00 + k, 1, "clr_held");
    idle_read(6, 7, 32'hC00, "clr_held_end");

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      bit r, w3, w4, c;
      r  = ($urandom_range(0, 199) == 0);
      w3 = r ? 1'b0 : 1'($urandom_range(0, 1));
      w4 = r ? 1'b0 : 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 24) == 0);
      pc = $urandom;
      drive(r, w3, $urandom_range(0, R - 1), $urandom, w4, $urandom_range(0, R - 1),
            $urandom, $urandom_range(0, R - 1), $urandom_range(0, R - 1), pc, c, "random");
    end
    drive(1'b0, 0, 0, '0, 0, 0, '0, 0, 1, 32'h0, 0, "random_tail");

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
